// File: rtl/vga_pos_if.sv
// Pixel-position bus: raster timing from the sync generator to pixel generators
// and to the VGA connector.
interface vga_pos_if;
    logic       pix_tick;
    logic [9:0] pos_h;
    logic [9:0] pos_v;
    logic       blank;
    logic       hsync;
    logic       vsync;
    logic       line_start;
    logic       frame_start;

    modport master (
        output pix_tick, pos_h, pos_v, blank, hsync, vsync, line_start, frame_start
    );

    modport slave (
        input pix_tick, pos_h, pos_v, blank, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate enable, h/v position counters,
// blanking, sync pulses and line/frame start strobes, all from registers.
module vga_sync_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned CLK_DIV  = 4,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    vga_pos_if.master  vga
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [3:0] DIV_LAST  = 4'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT     = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT     = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [3:0] div_cnt;
    logic [9:0] pos_h, pos_v;
    logic [9:0] h_next, v_next;
    logic       h_wrap, v_wrap;
    logic       pix_tick;
    logic       blank, hsync, vsync, line_start, frame_start;

    assign pix_tick = (div_cnt == DIV_LAST);

    // Next-state counters; decodes below are taken from these so every output
    // changes on the same edge as the counters they describe.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        h_next = pos_h;
        v_next = pos_v;
        h_wrap = 1'b0;
        v_wrap = 1'b0;
        if (pix_tick) begin
            if (pos_h == H_LAST) begin
                h_next = '0;
                h_wrap = 1'b1;
                if (pos_v == V_LAST) begin
                    v_next = '0;
                    v_wrap = 1'b1;
                end else begin
                    v_next = pos_v + 10'd1;
                end
            end else begin
                h_next = pos_h + 10'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt     <= '0;
            pos_h       <= '0;
            pos_v       <= '0;
            blank       <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            div_cnt     <= pix_tick ? '0 : div_cnt + 4'd1;
            pos_h       <= h_next;
            pos_v       <= v_next;
            blank       <= (h_next >= H_ACT) || (v_next >= V_ACT);
            hsync       <= ((h_next >= HS_START) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync       <= ((v_next >= VS_START) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end
    end

    assign vga.pix_tick    = pix_tick;
    assign vga.pos_h       = pos_h;
    assign vga.pos_v       = pos_v;
    assign vga.blank       = blank;
    assign vga.hsync       = hsync;
    assign vga.vsync       = vsync;
    assign vga.line_start  = line_start;
    assign vga.frame_start = frame_start;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (24x15 totals) so whole frames
// fit in a short run; a CLK_DIV=2 active-high-sync instance runs alongside.
module tb_vga_sync_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 8,  VF = 2, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int DIV_A = 4;
    localparam int DIV_B = 2;

    typedef struct packed {
        logic       tick;
        logic [9:0] h;
        logic [9:0] v;
        logic       blank;
        logic       hsync;
        logic       vsync;
        logic       ls;
        logic       fs;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_pos_if vga_a ();
    vga_pos_if vga_b ();

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV_A), .SYNC_POL(1'b0)
    ) dut_a (
        .clk(clk), .reset(reset), .vga(vga_a)
    );

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(DIV_B), .SYNC_POL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .vga(vga_b)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   n;
    int   last_ls_a, last_ls_b;
    int   frames_a, frames_b;
    bit   seen [4];
    obs_t q_a [$];
    obs_t q_b [$];
    obs_t last_exp_a;
    obs_t prev_a;

    // Expected outputs n cycles after the last reset edge, from elapsed time alone.
    function automatic obs_t model(input int cyc, input int div, input bit pol);
        obs_t o;
        int   p;
        p       = cyc / div;
        o.h     = 10'(p % HT);
        o.v     = 10'((p / HT) % VT);
        o.tick  = (cyc % div) == (div - 1);
        o.blank = (int'(o.h) >= HA) || (int'(o.v) >= VA);
        o.hsync = (int'(o.h) >= HA + HF && int'(o.h) < HA + HF + HS) ? pol : ~pol;
        o.vsync = (int'(o.v) >= VA + VF && int'(o.v) < VA + VF + VS) ? pol : ~pol;
        o.ls    = (cyc % div == 0) && (p > 0) && (o.h == 10'd0);
        o.fs    = o.ls && (o.v == 10'd0);
        return o;
    endfunction

    function automatic obs_t grab_a();
        return '{vga_a.pix_tick, vga_a.pos_h, vga_a.pos_v, vga_a.blank,
                 vga_a.hsync, vga_a.vsync, vga_a.line_start, vga_a.frame_start};
    endfunction

    function automatic obs_t grab_b();
        return '{vga_b.pix_tick, vga_b.pos_h, vga_b.pos_v, vga_b.blank,
                 vga_b.hsync, vga_b.vsync, vga_b.line_start, vga_b.frame_start};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, n);
        end
    endtask

    task automatic compare_now();
        obs_t ea, eb, ga, gb;
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        ga = grab_a();
        gb = grab_b();
        last_exp_a = ea;
        check("raster_a", 32'(ga), 32'(ea));
        check("raster_b", 32'(gb), 32'(eb));
        if (ga.ls) begin
            if (last_ls_a >= 0) check("line_period_a", n - last_ls_a, HT * DIV_A);
            last_ls_a = n;
        end
        if (gb.ls) begin
            if (last_ls_b >= 0) check("line_period_b", n - last_ls_b, HT * DIV_B);
            last_ls_b = n;
        end
        if (ga.fs) frames_a++;
        if (gb.fs) frames_b++;
        if (ga.h == 10'(HA - 1) && ga.v == 10'(VA - 1)) seen[0] = 1'b1;
        if (ga.h == 10'(HA)     && ga.v == 10'(VA - 1)) seen[1] = 1'b1;
        if (ga.h == 10'(HA - 1) && ga.v == 10'(VA))     seen[2] = 1'b1;
        if (prev_a.h == 10'(HT - 1) && prev_a.v == 10'(VT - 1) &&
            ga.h == 10'd0 && ga.v == 10'd0 && ga.fs) seen[3] = 1'b1;
        prev_a = ga;
    endtask

    // One clock: expectation queued at the edge, DUT compared half a cycle later.
    task automatic step();
        @(posedge clk);
        q_a.push_back(model(n, DIV_A, 1'b0));
        q_b.push_back(model(n, DIV_B, 1'b1));
        @(negedge clk);
        compare_now();
        n++;
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        n         = 0;
        last_ls_a = -1;
        last_ls_b = -1;
        frames_a  = 0;
        frames_b  = 0;
        prev_a    = '0;
        repeat (5) @(posedge clk);

        // Reset state, sampled in the last reset cycle (cycle 0 of the raster).
        @(negedge clk);
        q_a.push_back(model(0, DIV_A, 1'b0));
        q_b.push_back(model(0, DIV_B, 1'b1));
        compare_now();
        check("rst_pos_h",  32'(vga_a.pos_h), 0);
        check("rst_hsync",  32'(vga_a.hsync), 1);
        check("rst_hsync_b", 32'(vga_b.hsync), 0);
        check("rst_blank",  32'(vga_a.blank), 0);
        reset = 1'b0;
        n     = 1;

        // Two full frames of A (four of B).
        repeat (2 * HT * VT * DIV_A) step();
        check("frames_a", frames_a, 2);
        check("frames_b", frames_b, 4);

        // Run to a point inside both hsync and vsync, then pulse reset.
        found = 1'b0;
        for (int i = 0; i < HT * VT * DIV_A && !found; i++) begin
            step();
            found = (last_exp_a.h == 10'(HA + HF + 1)) && (last_exp_a.v == 10'(VA + VF));
        end
        check("reach_sync_point", 32'(found), 1);
        check("pre_rst_hsync", 32'(vga_a.hsync), 0);
        check("pre_rst_vsync", 32'(vga_a.vsync), 0);
        reset     = 1'b1;
        n         = 0;
        last_ls_a = -1;
        last_ls_b = -1;
        step();
        check("mid_rst_pos_h", 32'(vga_a.pos_h), 0);
        check("mid_rst_pos_v", 32'(vga_a.pos_v), 0);
        check("mid_rst_vsync", 32'(vga_a.vsync), 1);
        check("mid_rst_fs",    32'(vga_a.frame_start), 0);
        reset = 1'b0;

        // Raster resumes from the first-tick point.
        repeat (HT * VT * DIV_A + 8) step();

        for (int i = 0; i < 4; i++) check($sformatf("boundary_seen_%0d", i), 32'(seen[i]), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
